// File: rtl/universal_shift_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : universal_shift_reg_pkg
// Purpose  : Shared op / state encodings for the universal shift register.
// Revision : 1.0
// ============================================================================
package universal_shift_reg_pkg;

  typedef logic [2:0] op_t;

  localparam op_t OP_HOLD = 3'b000;
  localparam op_t OP_LOAD = 3'b001;
  localparam op_t OP_SHL  = 3'b010;
  localparam op_t OP_SHR  = 3'b011;
  localparam op_t OP_ROL  = 3'b100;
  localparam op_t OP_ROR  = 3'b101;
  localparam op_t OP_ASR  = 3'b110;
  localparam op_t OP_CLR  = 3'b111;

  typedef logic [0:0] state_t;

  localparam state_t ST_IDLE = 1'b0;
  localparam state_t ST_RUN  = 1'b1;

  // Only the shift/rotate family can be repeated by the sequencer.
  function automatic logic is_multi(input op_t o);
    return (o >= OP_SHL) && (o <= OP_ASR);
  endfunction

endpackage
`default_nettype wire

// File: rtl/universal_shift_reg_shift_unit.sv
`default_nettype none
// ============================================================================
// Module   : universal_shift_reg_shift_unit
// Purpose  : Combinational next-value generator for one application of op.
// Revision : 1.0
// ============================================================================
module universal_shift_reg_shift_unit
  import universal_shift_reg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] q,
  input  logic             si_l,
  input  logic             si_r,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] next_q
);

  always_comb begin
    next_q = q;
    case (op)
      OP_HOLD: next_q = q;
      OP_LOAD: next_q = d;
      OP_SHL:  next_q = {q[WIDTH-2:0], si_r};
      OP_SHR:  next_q = {si_l, q[WIDTH-1:1]};
      OP_ROL:  next_q = {q[WIDTH-2:0], q[WIDTH-1]};
      OP_ROR:  next_q = {q[0], q[WIDTH-1:1]};
      OP_ASR:  next_q = {q[WIDTH-1], q[WIDTH-1:1]};
      OP_CLR:  next_q = '0;
      default: next_q = q;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/universal_shift_reg.sv
`default_nettype none
// ============================================================================
// Module   : universal_shift_reg
// Purpose  : WIDTH-bit register with single-cycle ops and a shift-by-N sequencer.
// Revision : 1.0
// ============================================================================
module universal_shift_reg
  import universal_shift_reg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] d,
  input  logic             si_l,
  input  logic             si_r,
  input  logic             start,
  input  logic [AW-1:0]    amt,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar,
  output logic             so_l,
  output logic             so_r,
  output logic             busy,
  output logic             done
);

  state_t           r_state, w_state_nxt;
  op_t              r_op, w_op_nxt;
  logic [AW-1:0]    r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] r_q, w_q_nxt;
  logic             r_done, w_done_nxt;

  op_t              w_su_op;
  logic [WIDTH-1:0] w_su_q;

  // The same shifter serves both paths; RUN replays the latched op.
  assign w_su_op = (r_state == ST_RUN) ? r_op : op;

  universal_shift_reg_shift_unit #(
    .WIDTH (WIDTH)
  ) u_shift_unit (
    .op     (w_su_op),
    .q      (r_q),
    .si_l   (si_l),
    .si_r   (si_r),
    .d      (d),
    .next_q (w_su_q)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_op    <= OP_HOLD;
      r_cnt   <= '0;
      r_q     <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_op    <= w_op_nxt;
      r_cnt   <= w_cnt_nxt;
      r_q     <= w_q_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_op_nxt    = r_op;
    w_cnt_nxt   = r_cnt;
    w_q_nxt     = r_q;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start && is_multi(op)) begin
          // A zero count completes immediately without touching q.
          if (amt != '0) begin
            w_state_nxt = ST_RUN;
            w_op_nxt    = op;
            w_cnt_nxt   = amt;
          end else begin
            w_done_nxt  = 1'b1;
          end
        end else if (en) begin
          w_q_nxt = w_su_q;
        end
      end
      ST_RUN: begin
        w_q_nxt   = w_su_q;
        w_cnt_nxt = r_cnt - 1'b1;
        if (r_cnt == AW'(1)) begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    q     = r_q;
    q_bar = ~r_q;
    so_l  = r_q[WIDTH-1];
    so_r  = r_q[0];
    busy  = (r_state == ST_RUN);
    done  = r_done;
  end

endmodule
`default_nettype wire

// File: tb/tb_universal_shift_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_universal_shift_reg
// Purpose  : Scoreboard bench for universal_shift_reg (WIDTH=8, AW=4).
// Revision : 1.0
// ============================================================================
module tb_universal_shift_reg;

  localparam logic [2:0] OP_HOLD = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_SHL  = 3'b010;
  localparam logic [2:0] OP_SHR  = 3'b011;
  localparam logic [2:0] OP_ROL  = 3'b100;
  localparam logic [2:0] OP_ROR  = 3'b101;
  localparam logic [2:0] OP_ASR  = 3'b110;
  localparam logic [2:0] OP_CLR  = 3'b111;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       en, start, si_l, si_r;
  logic [2:0] op;
  logic [7:0] d;
  logic [3:0] amt;
  logic [7:0] q, q_bar;
  logic       so_l, so_r, busy, done;

  typedef struct {
    string      nm;
    logic [7:0] q;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  universal_shift_reg #(
    .WIDTH (8),
    .AW    (4)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (en),
    .op      (op),
    .d       (d),
    .si_l    (si_l),
    .si_r    (si_r),
    .start   (start),
    .amt     (amt),
    .q       (q),
    .q_bar   (q_bar),
    .so_l    (so_l),
    .so_r    (so_r),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rol8(input logic [7:0] v, input int n);
    logic [7:0] r;
    r = v;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  function automatic exp_t mk(input string nm, input logic [7:0] eq,
                              input logic eb, input logic ed);
    exp_t e;
    e.nm = nm; e.q = eq; e.busy = eb; e.done = ed;
    return e;
  endfunction

  // Drive one cycle of inputs and queue the state expected after the next edge.
  task automatic cyc(input string nm, input logic rn, input logic i_en,
                     input logic [2:0] i_op, input logic [7:0] i_d,
                     input logic i_sil, input logic i_sir, input logic i_start,
                     input logic [3:0] i_amt, input logic [7:0] eq,
                     input logic eb, input logic ed);
    @(negedge clk);
    #1;
    reset_n = rn; en = i_en; op = i_op; d = i_d;
    si_l = i_sil; si_r = i_sir; start = i_start; amt = i_amt;
    sb.push_back(mk(nm, eq, eb, ed));
  endtask

  // Monitor: every falling edge presents one registered result.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (q !== e.q || q_bar !== ~e.q || so_l !== e.q[7] || so_r !== e.q[0] ||
            busy !== e.busy || done !== e.done) begin
          errors++;
          $display("FAIL %s: got q=%h q_bar=%h so_l=%b so_r=%b busy=%b done=%b, expected q=%h q_bar=%h so_l=%b so_r=%b busy=%b done=%b",
                   e.nm, q, q_bar, so_l, so_r, busy, done,
                   e.q, ~e.q, e.q[7], e.q[0], e.busy, e.done);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 100000");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ev;
    reset_n = 1'b0; en = 1'b0; op = OP_HOLD; d = 8'h00;
    si_l = 1'b0; si_r = 1'b0; start = 1'b0; amt = 4'd0;

    // Reset dominates an active load
    cyc("reset0",     0, 1, OP_LOAD, 8'hFF, 0, 0, 0, 4'd0, 8'h00, 0, 0);
    cyc("reset1",     0, 0, OP_HOLD, 8'h00, 0, 0, 0, 4'd0, 8'h00, 0, 0);
    cyc("load_a5",    1, 1, OP_LOAD, 8'hA5, 0, 0, 0, 4'd0, 8'hA5, 0, 0);
    cyc("shl",        1, 1, OP_SHL,  8'h00, 0, 1, 0, 4'd0, 8'h4B, 0, 0);
    cyc("asr_pos",    1, 1, OP_ASR,  8'h00, 0, 0, 0, 4'd0, 8'h25, 0, 0);
    cyc("load_80",    1, 1, OP_LOAD, 8'h80, 0, 0, 0, 4'd0, 8'h80, 0, 0);
    cyc("asr_neg",    1, 1, OP_ASR,  8'h00, 0, 0, 0, 4'd0, 8'hC0, 0, 0);
    cyc("en0_clr",    1, 0, OP_CLR,  8'h00, 0, 0, 0, 4'd0, 8'hC0, 0, 0);
    cyc("en0_load",   1, 0, OP_LOAD, 8'h00, 1, 1, 0, 4'd0, 8'hC0, 0, 0);
    cyc("shr_si1",    1, 1, OP_SHR,  8'h00, 1, 0, 0, 4'd0, 8'hE0, 0, 0);
    cyc("rol",        1, 1, OP_ROL,  8'h00, 0, 0, 0, 4'd0, 8'hC1, 0, 0);
    cyc("ror",        1, 1, OP_ROR,  8'h00, 0, 0, 0, 4'd0, 8'hE0, 0, 0);
    cyc("clr",        1, 1, OP_CLR,  8'h00, 0, 0, 0, 4'd0, 8'h00, 0, 0);

    // Multi-cycle ROR by 3, with junk on the ignored inputs while busy
    cyc("load_01",    1, 1, OP_LOAD, 8'h01, 0, 0, 0, 4'd0, 8'h01, 0, 0);
    cyc("ror3_start", 1, 0, OP_ROR,  8'h00, 0, 0, 1, 4'd3, 8'h01, 1, 0);
    cyc("ror3_s1",    1, 1, OP_CLR,  8'hFF, 1, 1, 1, 4'd7, 8'h80, 1, 0);
    cyc("ror3_s2",    1, 1, OP_LOAD, 8'h55, 0, 1, 1, 4'd1, 8'h40, 1, 0);
    cyc("ror3_s3",    1, 1, OP_SHL,  8'hAA, 1, 0, 0, 4'd2, 8'h20, 0, 1);
    cyc("ror3_after", 1, 0, OP_HOLD, 8'h00, 0, 0, 0, 4'd0, 8'h20, 0, 0);

    // Zero count, then a start accepted while done is high
    cyc("amt0",       1, 1, OP_SHL,  8'h00, 0, 1, 1, 4'd0, 8'h20, 0, 1);
    cyc("b2b_start",  1, 0, OP_SHL,  8'h00, 0, 0, 1, 4'd2, 8'h20, 1, 0);
    cyc("b2b_s1",     1, 0, OP_HOLD, 8'h00, 0, 0, 0, 4'd0, 8'h40, 1, 0);
    cyc("b2b_s2",     1, 0, OP_HOLD, 8'h00, 0, 0, 0, 4'd0, 8'h80, 0, 1);
    cyc("b2b_after",  1, 0, OP_HOLD, 8'h00, 0, 0, 0, 4'd0, 8'h80, 0, 0);

    // start with a non-shift op behaves as a single-cycle op gated by en
    cyc("st_load_en", 1, 1, OP_LOAD, 8'h5A, 0, 0, 1, 4'd3, 8'h5A, 0, 0);
    cyc("st_load_n",  1, 0, OP_LOAD, 8'h00, 0, 0, 1, 4'd3, 8'h5A, 0, 0);

    // ROL by 5 on 0x81, async reset after the second step
    cyc("load_81",    1, 1, OP_LOAD, 8'h81, 0, 0, 0, 4'd0, 8'h81, 0, 0);
    cyc("rol5_start", 1, 0, OP_ROL,  8'h00, 0, 0, 1, 4'd5, 8'h81, 1, 0);
    cyc("rol5_s1",    1, 0, OP_HOLD, 8'h00, 0, 0, 0, 4'd0, 8'h03, 1, 0);
    @(negedge clk);
    #1;
    sb.push_back(mk("async_reset", 8'h00, 0, 0));
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    cyc("rst_hold",   0, 0, OP_HOLD, 8'h00, 0, 0, 0, 4'd0, 8'h00, 0, 0);
    cyc("rst_nodone", 1, 0, OP_HOLD, 8'h00, 0, 0, 0, 4'd0, 8'h00, 0, 0);
    cyc("rst_idle",   1, 0, OP_HOLD, 8'h00, 0, 0, 0, 4'd0, 8'h00, 0, 0);

    // Overlength logical shift: SHR by 10 with si_l=0 drains to zero
    cyc("load_ff",    1, 1, OP_LOAD, 8'hFF, 0, 0, 0, 4'd0, 8'hFF, 0, 0);
    cyc("shr10_start",1, 0, OP_SHR,  8'h00, 0, 0, 1, 4'd10, 8'hFF, 1, 0);
    for (int k = 1; k <= 10; k++) begin
      ev = 8'hFF >> k;
      cyc($sformatf("shr10_s%0d", k), 1, 1, OP_LOAD, 8'hAA, 0, 1, 0, 4'd0,
          ev, (k < 10), (k == 10));
    end
    cyc("shr10_after",1, 0, OP_HOLD, 8'h00, 0, 0, 0, 4'd0, 8'h00, 0, 0);

    // ROL by WIDTH returns the original value
    cyc("load_3c",    1, 1, OP_LOAD, 8'h3C, 0, 0, 0, 4'd0, 8'h3C, 0, 0);
    cyc("rol8_start", 1, 0, OP_ROL,  8'h00, 0, 0, 1, 4'd8, 8'h3C, 1, 0);
    for (int k = 1; k <= 8; k++) begin
      ev = rol8(8'h3C, k);
      cyc($sformatf("rol8_s%0d", k), 1, 0, OP_HOLD, 8'h00, 0, 0, 0, 4'd0,
          ev, (k < 8), (k == 8));
    end

    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d results still pending, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
